fpu_sqrt_seq: RTL

Sequencer wrapping the shared 26-bit fixed-point restoring square-root datapath, which is external to this block. Accepts an IEEE-754 single-precision operand over a valid/ready handshake. Special operands are resolved locally; normal operands have their radicand and exponent prepared, are held on the datapath for its pipeline latency, then rounded (RNE) and packed. The result is presented on a valid/ready output handshake with exception flags.

---
 rtl/fpu_sqrt_seq.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fpu_sqrt_seq.sv
// ============================================================================
// fpu_sqrt_seq : single-precision square-root sequencer around an external
//                26-bit restoring sqrt datapath (special cases, RNE, packing)
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_sqrt_seq #(
    parameter int SQRT_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        flag_invalid,
    output logic        flag_inexact,
    output logic        busy,
    output logic [25:0] sq_in,
    input  logic [25:0] sq_out,
    input  logic        sq_sticky
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0]  c_LAT  = 4'(SQRT_LAT);
    localparam logic [31:0] c_QNAN = 32'h7FC0_0000;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [25:0] sq_in_q, sq_in_d;
    logic [7:0]  er_q, er_d;
    logic [24:0] root_q, root_d;
    logic        sticky_q, sticky_d;
    logic [31:0] result_q, result_d;
    logic        inv_q, inv_d;
    logic        inx_q, inx_d;

    logic        w_s;
    logic [7:0]  w_e;
    logic [22:0] w_f;
    logic        w_special;
    logic [31:0] w_spec_res;
    logic        w_spec_inv;
    logic [25:0] w_rad;
    logic [8:0]  w_er_sum;
    logic        w_round_up;
    logic [23:0] w_m_sum;
    logic        w_unused;

    assign w_s = a[31];
    assign w_e = a[30:23];
    assign w_f = a[22:0];

    // Denormals share the zero path because any e==0 operand is treated as zero.
    always_comb begin
        w_special  = 1'b1;
        w_spec_res = c_QNAN;
        w_spec_inv = 1'b0;
        if (w_e == 8'hFF && w_f != 23'd0) begin
            w_spec_inv = ~w_f[22];
        end else if (w_e == 8'd0) begin
            w_spec_res = {w_s, 31'd0};
        end else if (w_s) begin
            w_spec_inv = 1'b1;
        end else if (w_e == 8'hFF) begin
            w_spec_res = 32'h7F80_0000;
        end else begin
            w_special  = 1'b0;
        end
    end

    assign w_rad    = w_e[0] ? {1'b1, w_f, 2'b00} : {2'b01, w_f, 1'b0};
    assign w_er_sum = {1'b0, w_e} + (w_e[0] ? 9'd127 : 9'd126);

    // Mantissa carry-out leaves m at zero, so only the exponent needs bumping.
    assign w_round_up = root_q[1] & (root_q[0] | sticky_q | root_q[2]);
    assign w_m_sum    = {1'b0, root_q[24:2]} + {23'd0, w_round_up};

    assign w_unused = &{1'b0, sq_out[25], w_er_sum[0]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sq_in_d  = sq_in_q;
        er_d     = er_q;
        root_d   = root_q;
        sticky_d = sticky_q;
        result_d = result_q;
        inv_d    = inv_q;
        inx_d    = inx_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (w_special) begin
                        result_d = w_spec_res;
                        inv_d    = w_spec_inv;
                        inx_d    = 1'b0;
                        state_d  = S_DONE;
                    end else begin
                        sq_in_d  = w_rad;
                        er_d     = w_er_sum[8:1];
                        cnt_d    = c_LAT;
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (cnt_q == 4'd0) begin
                    root_d   = sq_out[24:0];
                    sticky_d = sq_sticky;
                    state_d  = S_ROUND;
                end else begin
                    cnt_d    = cnt_q - 4'd1;
                end
            end
            S_ROUND: begin
                result_d = {1'b0, er_q + {7'd0, w_m_sum[23]}, w_m_sum[22:0]};
                inx_d    = root_q[1] | root_q[0] | sticky_q;
                inv_d    = 1'b0;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            sq_in_q  <= 26'd0;
            er_q     <= 8'd0;
            root_q   <= 25'd0;
            sticky_q <= 1'b0;
            result_q <= 32'd0;
            inv_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sq_in_q  <= sq_in_d;
            er_q     <= er_d;
            root_q   <= root_d;
            sticky_q <= sticky_d;
            result_q <= result_d;
            inv_q    <= inv_d;
            inx_q    <= inx_d;
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign out_valid    = (state_q == S_DONE);
    assign result       = result_q;
    assign flag_invalid = inv_q;
    assign flag_inexact = inx_q;
    assign sq_in        = sq_in_q;

endmodule

`default_nettype wire
